// File: rtl/shared_fu_pkg.sv
// Shared definitions for the shared functional-unit scheduler: op and state encodings plus a width helper.
package shared_fu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Minimum of one bit so a single-requester build still has a legal tag/pointer.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_fu_sched_if.sv
// Requester-side bus of the shared FU scheduler. req_lock exists only when SHARED_FU_LOCK_EN is defined.
interface shared_fu_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    // Handshake: requester i raises req_valid[i] with op/operands stable; the op transfers in
    // any cycle where req_valid[i] & req_ready[i]. rsp_valid is a one-cycle pulse with no backpressure.
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic                   flush;
    logic                   flush_done;
    logic                   busy;
`ifdef SHARED_FU_LOCK_EN
    logic [N_REQ-1:0]       req_lock;
`endif

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
`ifdef SHARED_FU_LOCK_EN
        output req_lock,
`endif
        input  req_ready, rsp_valid, rsp_data, flush_done, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
`ifdef SHARED_FU_LOCK_EN
        input  req_lock,
`endif
        output req_ready, rsp_valid, rsp_data, flush_done, busy
    );
endinterface

// File: rtl/shared_fu_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_fu_sched.sv
// Round-robin sharing of one fixed-latency add/mul unit with flush/drain sequencing.
// Optional grant locking is compiled in with SHARED_FU_LOCK_EN.
module shared_fu_sched
    import shared_fu_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 32,
    parameter int LAT      = 3
`ifdef SHARED_FU_LOCK_EN
    ,
    parameter int LOCK_MAX = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    shared_fu_sched_if.slave bus,
    output state_t           dbg_state
);
    localparam int PW = clog2(N_REQ);

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_adv;
    logic [N_REQ-1:0] arb_req, grant;
    logic [PW-1:0]    gidx;
    logic             gany, issue_en, xfer, busy_i;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic [LAT-1:0]   pv;
    logic [PW-1:0]    pown [LAT];
    logic [WIDTH-1:0] pdat [LAT];

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign issue_en      = reset && (state == ST_RUN) && !bus.flush;
    assign bus.req_ready = issue_en ? grant : '0;
    assign xfer          = issue_en && gany;
    assign ptr_adv       = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // Result is computed at issue and then only delayed, so add and mul share one latency.
    always_comb begin
        op_a   = bus.req_a[gidx*WIDTH +: WIDTH];
        op_b   = bus.req_b[gidx*WIDTH +: WIDTH];
        result = (bus.req_op[gidx] == OP_MUL) ? op_a * op_b : op_a + op_b;
    end

`ifdef SHARED_FU_LOCK_EN
    localparam int LCW = clog2(LOCK_MAX + 1);
    logic           lock_on, hold_lock;
    logic [PW-1:0]  lock_idx;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;

    always_comb begin
        arb_req = bus.req_valid;
        if (lock_on && bus.req_valid[lock_idx]) arb_req = N_REQ'(1) << lock_idx;
        lock_cnt_nxt = (lock_on && gidx == lock_idx) ? lock_cnt + LCW'(1) : LCW'(1);
        hold_lock    = bus.req_lock[gidx] && (int'(lock_cnt_nxt) < LOCK_MAX);
    end

    // A held lock keeps ptr parked; the grant that exhausts LOCK_MAX advances it normally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr      <= '0;
            lock_on  <= 1'b0;
            lock_idx <= '0;
            lock_cnt <= '0;
        end else if (xfer) begin
            if (hold_lock) begin
                lock_on  <= 1'b1;
                lock_idx <= gidx;
                lock_cnt <= lock_cnt_nxt;
            end else begin
                lock_on  <= 1'b0;
                lock_cnt <= '0;
                ptr      <= ptr_adv;
            end
        end else if (bus.flush || !bus.req_valid[lock_idx]) begin
            lock_on <= 1'b0;
        end
    end
`else
    assign arb_req = bus.req_valid;

    always_ff @(posedge clk) begin
        if (!reset)    ptr <= '0;
        else if (xfer) ptr <= ptr_adv;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) begin
                pown[k] <= '0;
                pdat[k] <= '0;
            end
        end else begin
            pv      <= {pv[LAT-2:0], xfer};
            pown[0] <= gidx;
            pdat[0] <= result;
            for (int k = 1; k < LAT; k++) begin
                pown[k] <= pown[k-1];
                pdat[k] <= pdat[k-1];
            end
        end
    end

    assign busy_i = |pv;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (bus.flush) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!busy_i)   state_nxt = ST_DONE;
            ST_DONE:  if (!bus.flush) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.rsp_valid[i] = reset && pv[LAT-1] && (pown[LAT-1] == PW'(i));
        end
        bus.rsp_data   = (reset && pv[LAT-1]) ? pdat[LAT-1] : '0;
        bus.busy       = reset && busy_i;
        bus.flush_done = reset && (state == ST_DONE);
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_shared_fu_sched.sv
// Directed bench for shared_fu_sched (N_REQ=4, WIDTH=32, LAT=3); lock vectors run when SHARED_FU_LOCK_EN is defined.
module tb_shared_fu_sched;
    import shared_fu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    state_t      dbg_state;
    logic [31:0] cyc = '0;
    int          chk_cnt = 0;
    int          fail_cnt = 0;

    // Expected response: {owner one-hot[67:64], data[63:32], cycle[31:0]}
    logic [67:0] exp_q[$];
    logic [67:0] e;

    shared_fu_sched_if #(.N_REQ(4), .WIDTH(32)) bus ();

    shared_fu_sched #(.N_REQ(4), .WIDTH(32), .LAT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i]         = op;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic issue(input string tag, input logic [3:0] exp_gnt, input logic [31:0] exp_data);
        @(negedge clk);
        check(tag, bus.req_ready, exp_gnt);
        if (exp_gnt != 4'b0) exp_q.push_back({exp_gnt, exp_data, cyc + 32'd3});
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_flush_done"}, bus.flush_done, 0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (e[31:0] < cyc) begin
                void'(exp_q.pop_front());
                check("rsp_missing", cyc, e[31:0]);
            end
        end
        if (|bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", bus.rsp_valid, e[67:64]);
                check("rsp_data", bus.rsp_data, e[63:32]);
                check("rsp_cycle", cyc, e[31:0]);
            end
        end
    end

    int          t3_req  [4] = '{2, 3, 1, 0};
    logic        t3_op   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t3_a    [4] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'd3, 32'h0001_0001};
    logic [31:0] t3_b    [4] = '{32'd1, 32'h0001_0000, 32'd4, 32'h0001_0001};
    logic [31:0] t3_exp  [4] = '{32'd0, 32'd0, 32'd12, 32'h0002_0001};

    initial begin
        reset         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush     = 1'b0;
`ifdef SHARED_FU_LOCK_EN
        bus.req_lock  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check_quiet("rst");
        check("rst_state", dbg_state, ST_RUN);
        bus.req_valid = '0;
        tick();
        reset = 1'b1;

        // all four valid from ptr=0: 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_op(i, OP_ADD, 32'(10 * i + 1), 32'd2);
        bus.req_valid = 4'b1111;
        issue("t2_gnt0", 4'b0001, 32'd3);
        issue("t2_gnt1", 4'b0010, 32'd13);
        issue("t2_gnt2", 4'b0100, 32'd23);
        issue("t2_gnt3", 4'b1000, 32'd33);
        issue("t2_gnt4", 4'b0001, 32'd3);
        bus.req_valid = '0;
        repeat (4) tick();

        // single add with busy window
        set_op(0, OP_ADD, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        issue("t1_gnt", 4'b0001, 32'd12);
        bus.req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t1_busy", bus.busy, (k <= 3) ? 1 : 0);
            tick();
        end

        // wrap / width vectors
        for (int i = 0; i < 4; i++) begin
            set_op(t3_req[i], t3_op[i], t3_a[i], t3_b[i]);
            bus.req_valid = 4'b0001 << t3_req[i];
            issue("t3_gnt", 4'b0001 << t3_req[i], t3_exp[i]);
        end
        bus.req_valid = '0;
        repeat (4) tick();

        // flush with two ops in flight
        set_op(0, OP_ADD, 32'd1, 32'd1);
        set_op(1, OP_ADD, 32'd2, 32'd2);
        set_op(2, OP_ADD, 32'd5, 32'd5);
        bus.req_valid = 4'b0001;
        issue("t4_gnt0", 4'b0001, 32'd2);
        bus.req_valid = 4'b0010;
        issue("t4_gnt1", 4'b0010, 32'd4);
        bus.req_valid = 4'b0100;
        bus.flush     = 1'b1;
        issue("t4_flush_blocks", 4'b0000, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_drain_ready", bus.req_ready, 0);
            check("t4_flush_done", bus.flush_done, (k == 3) ? 1 : 0);
            check("t4_state", dbg_state, (k == 3) ? ST_DONE : ST_DRAIN);
            tick();
        end
        bus.flush = 1'b0;
        @(negedge clk);
        check("t4_done_hold", bus.flush_done, 1);
        check("t4_done_ready", bus.req_ready, 0);
        tick();
        issue("t4_resume_gnt", 4'b0100, 32'd10);
        bus.req_valid = '0;
        check("t4_flush_done_low", bus.flush_done, 0);
        repeat (4) tick();

        // reset with three ops in flight
        set_op(0, OP_ADD, 32'd1, 32'd2);
        set_op(1, OP_MUL, 32'd2, 32'd3);
        set_op(2, OP_ADD, 32'd4, 32'd4);
        bus.req_valid = 4'b0001;
        issue("t5_gnt0", 4'b0001, 32'd3);
        bus.req_valid = 4'b0010;
        issue("t5_gnt1", 4'b0010, 32'd6);
        bus.req_valid = 4'b0100;
        issue("t5_gnt2", 4'b0100, 32'd8);
        bus.req_valid = '0;
        reset = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_quiet("t5_post_rst");
        check("t5_state", dbg_state, ST_RUN);
        tick();
        set_op(0, OP_ADD, 32'd7, 32'd8);
        set_op(3, OP_ADD, 32'd9, 32'd9);
        bus.req_valid = 4'b1001;
        issue("t5_ptr_zero", 4'b0001, 32'd15);
        bus.req_valid = '0;
        repeat (4) tick();

`ifdef SHARED_FU_LOCK_EN
        // req1 locked vs req2: 1,1,1,1 then 2
        set_op(1, OP_ADD, 32'd1, 32'd1);
        set_op(2, OP_ADD, 32'd2, 32'd3);
        bus.req_lock  = 4'b0010;
        bus.req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) issue("t6_lock_gnt", 4'b0010, 32'd2);
        issue("t6_release_gnt", 4'b0100, 32'd5);
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (4) tick();
`endif

        repeat (4) tick();
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
